multicycle_uc: RTL and testbench
================================

Name: multicycle_uc

Overview:
- Multi-cycle MIPS control unit; the next generation of the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states instead of decoding in one cycle.
- Stretches memory states with a memory-ready handshake, flags illegal opcodes, and counts retired instructions.
- Sits between the instruction register opcode field and the shared-memory datapath (PC, IR, register file, ALU, memory).

Parameters:
- OPW, 6, opcode width.
- ALUOPW, 3, ALUop width (≥3). ALUop encoding: add = 0, sub = 1, funct-decode = all ones.
- CNT_W, 16, retired-instruction counter width.
- OP_R, 6'b000000, R-type opcode.
- OP_LW, 6'b100011, load-word opcode.
- OP_SW, 6'b101011, store-word opcode.
- OP_BEQ, 6'b000100, branch-equal opcode.
- OP_ADDI, 6'b001000, add-immediate opcode.
- OP_J, 6'b000010, jump opcode.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- inscod  in  OPW  opcode from IR; sampled only in DECODE.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- Branch  out  1  conditional PC load (datapath ANDs with ALU zero).
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  IR load.
- Memtoreg  out  1  register write data: 1 = MDR, 0 = ALUOut.
- RegDist  out  1  write register: 1 = rd, 0 = rt.
- Regwrite  out  1  register file write enable.
- ALUsrcA  out  1  0 = PC, 1 = register A.
- ALUsrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- ALUop  out  ALUOPW  ALU operation.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state encoding (debug).
- illegal  out  1  sticky illegal-opcode flag.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, rst_n = 0): state = FETCH, illegal = 0, retired = 0. Reset mid-instruction aborts it immediately with no retire.
- Outputs are Moore from the registered state, except IRWrite/PCWrite in FETCH, which are gated by mem_ready.
- Any output not listed for a state is 0.
- State encodings and outputs:
  - 0 FETCH: MemRead = 1, IorD = 0, ALUsrcA = 0, ALUsrcB = 01, ALUop = add, PCSource = 00, IRWrite = PCWrite = mem_ready. Stay while mem_ready = 0; go to DECODE when mem_ready = 1.
  - 1 DECODE: ALUsrcA = 0, ALUsrcB = 11, ALUop = add. Next state by inscod: LW/SW→MEM_ADDR, R→R_EXEC, BEQ→BRANCH, ADDI→ADDI_EXEC, J→JUMP, any other→TRAP.
  - 2 MEM_ADDR: ALUsrcA = 1, ALUsrcB = 10, ALUop = add. LW→MEM_RD, SW→MEM_WR. The opcode is held in an internal register captured in DECODE, because the IR input may change.
  - 3 MEM_RD: MemRead = 1, IorD = 1. Wait for mem_ready, then go to MEM_WB.
  - 4 MEM_WB: Regwrite = 1, Memtoreg = 1, RegDist = 0. Go to FETCH and retire.
  - 5 MEM_WR: MemWrite = 1, IorD = 1. Wait for mem_ready, then go to FETCH and retire.
  - 6 R_EXEC: ALUsrcA = 1, ALUsrcB = 00, ALUop = all ones. Go to R_WB.
  - 7 R_WB: RegDist = 1, Regwrite = 1, Memtoreg = 0. Go to FETCH and retire.
  - 8 BRANCH: ALUsrcA = 1, ALUsrcB = 00, ALUop = sub, Branch = 1, PCSource = 01. Go to FETCH and retire.
  - 9 ADDI_EXEC: ALUsrcA = 1, ALUsrcB = 10, ALUop = add. Go to ADDI_WB.
  - 10 ADDI_WB: Regwrite = 1, RegDist = 0, Memtoreg = 0. Go to FETCH and retire.
  - 11 JUMP: PCWrite = 1, PCSource = 10. Go to FETCH and retire.
  - 12 TRAP: set illegal = 1, which stays set until reset. Go to FETCH with no retire.
  - Unused encodings 13–15: go to FETCH next cycle with all outputs 0.
- Retire: retired increments by 1 on the clock edge leaving a completing state. It wraps from all ones to 0 silently.
- Latency with mem_ready tied to 1:
  - R-type, ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ, J: 3 cycles.
  - Each cycle mem_ready is low adds 1 cycle in FETCH, MEM_RD or MEM_WR.
- MemRead and MemWrite are never both 1. Regwrite is never 1 in the same cycle as MemWrite.

Test Plan:
- Reset → all control outputs 0 except FETCH defaults (MemRead = 1, ALUsrcB = 01); retired = 0, illegal = 0. Then mem_ready = 1 with inscod = 000000 → states 0,1,6,7,0; ALUop = 111 in R_EXEC; RegDist = Regwrite = 1 in R_WB; retired = 1.
- LW (100011), mem_ready held low 2 cycles in FETCH and 3 in MEM_RD → 10 cycles total; Memtoreg = 1 only in MEM_WB; IRWrite pulses exactly once.
- SW, BEQ, J, ADDI back-to-back with mem_ready = 1 → cycle counts 4, 3, 3, 4; Branch = 1 only in BRANCH; PCSource = 10 in JUMP; retired = 4.
- inscod = 111111 → DECODE→TRAP→FETCH; illegal = 1 and stays 1 through later valid instructions; retired unchanged.
- Pulse rst_n low mid-MEM_RD (asynchronously, between edges) → state = 0 immediately, illegal = 0, retired = 0.
- Preload near wrap (CNT_W = 4): 16 R-type instructions → retired goes 15→0.

Source files
------------

// File: rtl/multicycle_uc.sv
// Multi-cycle MIPS control unit: walks each instruction through fetch, decode,
// execute, memory and write-back states, with memory wait states, an illegal-opcode flag and a retire counter.
module multicycle_uc #(
  parameter int             OPW     = 6,
  parameter int             ALUOPW  = 3,
  parameter int             CNT_W   = 16,
  parameter logic [OPW-1:0] OP_R    = 6'b000000,
  parameter logic [OPW-1:0] OP_LW   = 6'b100011,
  parameter logic [OPW-1:0] OP_SW   = 6'b101011,
  parameter logic [OPW-1:0] OP_BEQ  = 6'b000100,
  parameter logic [OPW-1:0] OP_ADDI = 6'b001000,
  parameter logic [OPW-1:0] OP_J    = 6'b000010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPW-1:0]    inscod,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic              Branch,
  output logic              IorD,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              Memtoreg,
  output logic              RegDist,
  output logic              Regwrite,
  output logic              ALUsrcA,
  output logic [1:0]        ALUsrcB,
  output logic [ALUOPW-1:0] ALUop,
  output logic [1:0]        PCSource,
  output logic [3:0]        state,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  // Memory handshake: mem_ready high in FETCH, MEM_RD or MEM_WR means the
  // access requested in that cycle completes at the next rising edge; in
  // every other state mem_ready is ignored.

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  typedef struct packed {
    logic              pc_write;
    logic              branch;
    logic              iord;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_dst;
    logic              reg_write;
    logic              alu_src_a;
    logic [1:0]        alu_src_b;
    logic [ALUOPW-1:0] alu_op;
    logic [1:0]        pc_source;
  } ctrl_t;

  localparam logic [ALUOPW-1:0] ALU_ADD   = '0;
  localparam logic [ALUOPW-1:0] ALU_SUB   = ALUOPW'(1);
  localparam logic [ALUOPW-1:0] ALU_FUNCT = '1;

  state_t          state_q;
  state_t          state_d;
  ctrl_t           ctrl_q;
  logic [OPW-1:0]  op_q;
  logic            retire_now;
  logic            illegal_q;
  logic [CNT_W-1:0] retired_q;

  // Control word for a state; FETCH's mem_ready-gated strobes are added outside.
  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b00;
        c.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b00;
        c.alu_op    = ALU_SUB;
        c.branch    = 1'b1;
        c.pc_source = 2'b01;
      end
      S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
      end
      S_ADDI_WB: begin
        c.reg_write = 1'b1;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (inscod == OP_LW || inscod == OP_SW) state_d = S_MEM_ADDR;
        else if (inscod == OP_R)                state_d = S_R_EXEC;
        else if (inscod == OP_BEQ)              state_d = S_BRANCH;
        else if (inscod == OP_ADDI)             state_d = S_ADDI_EXEC;
        else if (inscod == OP_J)                state_d = S_JUMP;
        else                                    state_d = S_TRAP;
      end
      // The IR may already hold something else here, so use the captured opcode.
      S_MEM_ADDR:  state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WR:    state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_TRAP:      state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  always_comb begin
    retire_now = 1'b0;
    case (state_q)
      S_MEM_WB, S_R_WB, S_BRANCH, S_ADDI_WB, S_JUMP: retire_now = 1'b1;
      S_MEM_WR: retire_now = mem_ready;
      default:  retire_now = 1'b0;
    endcase
  end

  // The control word is registered from the next state, so it always matches state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ctrl_q    <= ctrl_of(S_FETCH);
      op_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
      if (state_q == S_DECODE) op_q <= inscod;
      if (state_q == S_TRAP) illegal_q <= 1'b1;
      if (retire_now) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign IRWrite  = (state_q == S_FETCH) && mem_ready;
  assign PCWrite  = ctrl_q.pc_write | IRWrite;
  assign Branch   = ctrl_q.branch;
  assign IorD     = ctrl_q.iord;
  assign MemRead  = ctrl_q.mem_read;
  assign MemWrite = ctrl_q.mem_write;
  assign Memtoreg = ctrl_q.mem_to_reg;
  assign RegDist  = ctrl_q.reg_dst;
  assign Regwrite = ctrl_q.reg_write;
  assign ALUsrcA  = ctrl_q.alu_src_a;
  assign ALUsrcB  = ctrl_q.alu_src_b;
  assign ALUop    = ctrl_q.alu_op;
  assign PCSource = ctrl_q.pc_source;
  assign state    = state_q;
  assign illegal  = illegal_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_uc.sv
// Bench for multicycle_uc: drives instruction sequences with wait states and
// checks every cycle's control word, sticky flag and retire count from a queue.
module tb_multicycle_uc;

  localparam int CW = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2,
                         S_MEM_RD = 4'd3, S_MEM_WB = 4'd4, S_MEM_WR = 4'd5,
                         S_R_EXEC = 4'd6, S_R_WB = 4'd7, S_BRANCH = 4'd8,
                         S_ADDI_EXEC = 4'd9, S_ADDI_WB = 4'd10, S_JUMP = 4'd11,
                         S_TRAP = 4'd12;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]    inscod = '0;
  logic          mem_ready = 1'b0;
  logic          pc_write, branch, iord, mem_read, mem_write, ir_write;
  logic          mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]    alu_src_b, pc_source;
  logic [2:0]    alu_op;
  logic [3:0]    state;
  logic          illegal;
  logic [CW-1:0] retired;

  multicycle_uc #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .inscod(inscod), .mem_ready(mem_ready),
    .PCWrite(pc_write), .Branch(branch), .IorD(iord), .MemRead(mem_read),
    .MemWrite(mem_write), .IRWrite(ir_write), .Memtoreg(mem_to_reg),
    .RegDist(reg_dst), .Regwrite(reg_write), .ALUsrcA(alu_src_a),
    .ALUsrcB(alu_src_b), .ALUop(alu_op), .PCSource(pc_source),
    .state(state), .illegal(illegal), .retired(retired)
  );

  wire [20:0] dut_vec = {pc_write, branch, iord, mem_read, mem_write, ir_write,
                         mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                         alu_op, pc_source, state};

  // scoreboard: {control word, illegal, retired} per cycle
  logic [25:0]   exp_q[$];
  logic [25:0]   e;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [CW-1:0] m_retired = '0;
  logic          m_illegal = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference control word per state, straight from the state table.
  function automatic logic [20:0] exp_vec(input logic [3:0] st, input logic mr);
    logic pcw, br, io, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    {pcw, br, io, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (st)
      S_FETCH:     begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
      S_DECODE:    asb = 2'b11;
      S_MEM_ADDR:  begin asa = 1'b1; asb = 2'b10; end
      S_MEM_RD:    begin mrd = 1'b1; io = 1'b1; end
      S_MEM_WB:    begin rw = 1'b1; m2r = 1'b1; end
      S_MEM_WR:    begin mwr = 1'b1; io = 1'b1; end
      S_R_EXEC:    begin asa = 1'b1; aop = 3'b111; end
      S_R_WB:      begin rdst = 1'b1; rw = 1'b1; end
      S_BRANCH:    begin asa = 1'b1; aop = 3'b001; br = 1'b1; pcs = 2'b01; end
      S_ADDI_EXEC: begin asa = 1'b1; asb = 2'b10; end
      S_ADDI_WB:   rw = 1'b1;
      S_JUMP:      begin pcw = 1'b1; pcs = 2'b10; end
      default:     ;
    endcase
    return {pcw, br, io, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, st};
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // driver: one cycle, called at posedge+1
  task automatic step(input logic [3:0] st, input logic mr, input bit ret, input bit trap);
    mem_ready = mr;
    exp_q.push_back({exp_vec(st, mr), m_illegal, m_retired});
    if (ret) m_retired = m_retired + 4'd1;
    if (trap) m_illegal = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    inscod = op;
    repeat (fw) step(S_FETCH, 1'b0, 0, 0);
    step(S_FETCH, 1'b1, 0, 0);
    step(S_DECODE, rnd_bit(), 0, 0);
    inscod = 6'($urandom);
    case (op)
      OP_LW: begin
        step(S_MEM_ADDR, rnd_bit(), 0, 0);
        repeat (mw) step(S_MEM_RD, 1'b0, 0, 0);
        step(S_MEM_RD, 1'b1, 0, 0);
        step(S_MEM_WB, rnd_bit(), 1, 0);
      end
      OP_SW: begin
        step(S_MEM_ADDR, rnd_bit(), 0, 0);
        repeat (mw) step(S_MEM_WR, 1'b0, 0, 0);
        step(S_MEM_WR, 1'b1, 1, 0);
      end
      OP_R: begin
        step(S_R_EXEC, rnd_bit(), 0, 0);
        step(S_R_WB, rnd_bit(), 1, 0);
      end
      OP_BEQ:  step(S_BRANCH, rnd_bit(), 1, 0);
      OP_ADDI: begin
        step(S_ADDI_EXEC, rnd_bit(), 0, 0);
        step(S_ADDI_WB, rnd_bit(), 1, 0);
      end
      OP_J:    step(S_JUMP, rnd_bit(), 1, 0);
      default: step(S_TRAP, rnd_bit(), 0, 1);
    endcase
  endtask

  // Async reset asserted between edges while a load waits in MEM_RD.
  task automatic reset_mid_memrd();
    inscod = OP_LW;
    step(S_FETCH, 1'b1, 0, 0);
    step(S_DECODE, 1'b1, 0, 0);
    step(S_MEM_ADDR, 1'b1, 0, 0);
    step(S_MEM_RD, 1'b0, 0, 0);
    mem_ready = 1'b0;
    check("pre_rst_state", state, S_MEM_RD);
    #2 rst_n = 1'b0;
    #1;
    check("rst_state", state, S_FETCH);
    check("rst_illegal", illegal, 0);
    check("rst_retired", retired, 0);
    check("rst_ctrl", dut_vec, exp_vec(S_FETCH, 1'b0));
    #2 rst_n = 1'b1;
    m_retired = '0;
    m_illegal = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("ctrl", dut_vec, e[25:5]);
      check("illegal", illegal, e[4]);
      check("retired", retired, e[3:0]);
      check("rd_wr_excl", mem_read & mem_write, 0);
      check("wr_regw_excl", reg_write & mem_write, 0);
    end
  end

  logic [5:0] op_tbl[7];

  initial begin
    op_tbl[0] = OP_R;  op_tbl[1] = OP_LW;   op_tbl[2] = OP_SW; op_tbl[3] = OP_BEQ;
    op_tbl[4] = OP_ADDI; op_tbl[5] = OP_J; op_tbl[6] = 6'b010101;

    #7;
    check("reset_state", state, S_FETCH);
    check("reset_ctrl", dut_vec, exp_vec(S_FETCH, 1'b0));
    check("reset_illegal", illegal, 0);
    check("reset_retired", retired, 0);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_instr(OP_R, 0, 0);
    check("retired_r", retired, 1);
    run_instr(OP_LW, 2, 3);
    check("retired_lw", retired, 2);
    run_instr(OP_SW, 0, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, 0);
    run_instr(OP_ADDI, 0, 0);
    check("retired_mix", retired, 6);

    run_instr(6'b111111, 0, 0);
    check("illegal_set", illegal, 1);
    check("trap_no_retire", retired, 6);
    run_instr(OP_R, 1, 0);
    run_instr(OP_SW, 0, 2);
    check("illegal_sticky", illegal, 1);

    for (int i = 0; i < 12; i++)
      run_instr(op_tbl[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 2));

    reset_mid_memrd();

    repeat (15) run_instr(OP_R, 0, 0);
    check("wrap_pre", retired, 15);
    run_instr(OP_R, 0, 0);
    check("wrap_post", retired, 0);

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
